// File: rtl/ped_pkg.sv
// Shared types and default timing constants for the pedestrian button front end.
// Also used by the crossing controller so both agree on press timing.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    WAIT_ACK = 2'd2,
    LOCKOUT  = 2'd3
  } ped_state_e;

  localparam int PED_DEBOUNCE_CYCLES = 2;
  localparam int PED_LONG_CYCLES     = 5;
  localparam int PED_LOCKOUT_CYCLES  = 8;
  localparam int PED_CNT_W           = 8;

endpackage

// File: rtl/ped_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for the raw button.
// The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PED_DEBOUNCE_CYCLES,
  parameter int CNT_W           = PED_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic btn_stable
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  // Counter restarts on any agreeing sample, so short pulses never accumulate.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (s2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = ~stable_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      s1_q      <= button;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_stable = stable_q;

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian button front end: debounce, short/long classification, req/ack and lockout.
// Define PED_PRESS_COUNT_EN to add the press_count output (acknowledged requests, saturating).
module ped_button_conditioner
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PED_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = PED_LONG_CYCLES,
  parameter int LOCKOUT_CYCLES  = PED_LOCKOUT_CYCLES,
  parameter int CNT_W           = PED_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       ped_ack,
  output logic       ped_req,
  output logic       ped_long,
  output logic       btn_stable,
  output logic       lockout
`ifdef PED_PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCKOUT_CYCLES);

  ped_state_e       state_q, state_d;
  logic             prev_q;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic             req_q, req_d;
  logic             long_q, long_d;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .btn_stable(btn_stable)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lock_d  = lock_q;
    req_d   = req_q;
    long_d  = long_q;
    case (state_q)
      IDLE: begin
        if (btn_stable && !prev_q) begin
          state_d = PRESSED;
          hold_d  = CNT_W'(1);
        end
      end
      PRESSED: begin
        // A long press is reported while still held; release is not awaited.
        if (btn_stable) begin
          hold_d = hold_q + CNT_W'(1);
          if (hold_q == LONG_LAST) begin
            state_d = WAIT_ACK;
            req_d   = 1'b1;
            long_d  = 1'b1;
          end
        end else begin
          state_d = WAIT_ACK;
          req_d   = 1'b1;
          long_d  = 1'b0;
        end
      end
      WAIT_ACK: begin
        if (ped_ack) begin
          state_d = LOCKOUT;
          req_d   = 1'b0;
          long_d  = 1'b0;
          lock_d  = '0;
        end
      end
      LOCKOUT: begin
        if (lock_q != LOCK_MAX) begin
          lock_d = lock_q + CNT_W'(1);
        end
        // Leave on the edge the count reaches its limit, but never while still held.
        if ((lock_q >= LOCK_LAST) && !btn_stable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      hold_q  <= '0;
      lock_q  <= '0;
      req_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= btn_stable;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      req_q   <= req_d;
      long_q  <= long_d;
    end
  end

  assign ped_req  = req_q;
  assign ped_long = long_q;
  assign lockout  = (state_q == LOCKOUT);

`ifdef PED_PRESS_COUNT_EN
  logic       ack_evt;
  logic [7:0] press_count_q;

  assign ack_evt = (state_q == WAIT_ACK) && ped_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_count_q <= 8'd0;
    end else if (ack_evt && (press_count_q != 8'hFF)) begin
      press_count_q <= press_count_q + 8'd1;
    end
  end

  assign press_count = press_count_q;
`endif

endmodule
